// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path constants and fetch queue sizing.
package fetch_queue_pkg;
   localparam int ADDR_LEN    = 32;
   localparam int INSN_LEN    = 32;
   localparam int GSH_BHR_LEN = 10;

   localparam int FQ_DEPTH   = 4;
   localparam int FQ_PKT_LEN = 2*ADDR_LEN + 2*INSN_LEN + 2 + GSH_BHR_LEN;

   // Occupancy counter width: must represent 0..depth inclusive.
   function automatic int fq_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/fetch_queue_ram.sv
// Packet storage: register array, one synchronous write port, one async read port.
module fetch_queue_ram #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);
   logic [DEPTH-1:0][WIDTH-1:0] mem;

   // Payload is intentionally not reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO with mispredict flush.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH    = FQ_DEPTH,
   parameter int ADDR_LEN = fetch_queue_pkg::ADDR_LEN,
   parameter int INSN_LEN = fetch_queue_pkg::INSN_LEN,
   parameter int BHR_LEN  = fetch_queue_pkg::GSH_BHR_LEN
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             enq_valid,
   output logic                             enq_ready,
   input  logic [ADDR_LEN-1:0]              enq_pc,
   input  logic [ADDR_LEN-1:0]              enq_npc,
   input  logic [INSN_LEN-1:0]              enq_inst1,
   input  logic [INSN_LEN-1:0]              enq_inst2,
   input  logic                             enq_invalid2,
   input  logic                             enq_predict_cond,
   input  logic [BHR_LEN-1:0]               enq_bhr,
   output logic                             deq_valid,
   input  logic                             deq_ready,
   output logic [ADDR_LEN-1:0]              deq_pc,
   output logic [ADDR_LEN-1:0]              deq_npc,
   output logic [INSN_LEN-1:0]              deq_inst1,
   output logic [INSN_LEN-1:0]              deq_inst2,
   output logic                             deq_invalid2,
   output logic                             deq_predict_cond,
   output logic [BHR_LEN-1:0]               deq_bhr,
   input  logic                             prmiss,
   output logic [fq_cnt_w(DEPTH)-1:0]       count
);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = fq_cnt_w(DEPTH);
   localparam int PKT_LEN = 2*ADDR_LEN + 2*INSN_LEN + 2 + BHR_LEN;

   logic [PTR_W-1:0]   rdptr, wrptr;
   logic [PKT_LEN-1:0] wr_pkt, rd_pkt;
   logic               enq_fire, deq_fire;

   // Ready/valid come only from registered count: no deq->enq or enq->deq paths.
   assign enq_ready = (count != CNT_W'(DEPTH));
   assign deq_valid = (count != '0);
   assign enq_fire  = enq_valid & enq_ready & ~prmiss;
   assign deq_fire  = deq_valid & deq_ready & ~prmiss;

   assign wr_pkt = {enq_pc, enq_npc, enq_inst1, enq_inst2,
                    enq_invalid2, enq_predict_cond, enq_bhr};
   assign {deq_pc, deq_npc, deq_inst1, deq_inst2,
           deq_invalid2, deq_predict_cond, deq_bhr} = rd_pkt;

   // Pointer/occupancy control; reset and flush both discard every entry.
   always_ff @(posedge clk) begin
      if (reset || prmiss) begin
         rdptr <= '0;
         wrptr <= '0;
         count <= '0;
      end else begin
         if (enq_fire) wrptr <= wrptr + PTR_W'(1);
         if (deq_fire) rdptr <= rdptr + PTR_W'(1);
         count <= count + CNT_W'(enq_fire) - CNT_W'(deq_fire);
      end
   end

   fetch_queue_ram #(
      .DEPTH (DEPTH),
      .WIDTH (PKT_LEN)
   ) u_ram (
      .clk   (clk),
      .we    (enq_fire),
      .waddr (wrptr),
      .wdata (wr_pkt),
      .raddr (rdptr),
      .rdata (rd_pkt)
   );
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized + directed check of fetch_queue against a queue-based model.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int DEPTH = FQ_DEPTH;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef struct {
      logic [ADDR_LEN-1:0]    pc, npc;
      logic [INSN_LEN-1:0]    i1, i2;
      logic                   inv2, pcnd;
      logic [GSH_BHR_LEN-1:0] bhr;
   } pkt_t;

   logic                   clk = 1'b0;
   logic                   reset, enq_valid, enq_ready, deq_valid, deq_ready, prmiss;
   logic [ADDR_LEN-1:0]    enq_pc, enq_npc, deq_pc, deq_npc;
   logic [INSN_LEN-1:0]    enq_inst1, enq_inst2, deq_inst1, deq_inst2;
   logic                   enq_invalid2, enq_predict_cond, deq_invalid2, deq_predict_cond;
   logic [GSH_BHR_LEN-1:0] enq_bhr, deq_bhr;
   logic [CNT_W-1:0]       count;

   int   n_chk = 0;
   int   n_err = 0;
   pkt_t exp_q[$];

   always #5 clk = ~clk;

   fetch_queue dut (
      .clk(clk), .reset(reset),
      .enq_valid(enq_valid), .enq_ready(enq_ready),
      .enq_pc(enq_pc), .enq_npc(enq_npc), .enq_inst1(enq_inst1), .enq_inst2(enq_inst2),
      .enq_invalid2(enq_invalid2), .enq_predict_cond(enq_predict_cond), .enq_bhr(enq_bhr),
      .deq_valid(deq_valid), .deq_ready(deq_ready),
      .deq_pc(deq_pc), .deq_npc(deq_npc), .deq_inst1(deq_inst1), .deq_inst2(deq_inst2),
      .deq_invalid2(deq_invalid2), .deq_predict_cond(deq_predict_cond), .deq_bhr(deq_bhr),
      .prmiss(prmiss), .count(count)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive a packet with random payload around a chosen PC.
   task automatic set_pkt(input logic [ADDR_LEN-1:0] pc);
      enq_pc           = pc;
      enq_npc          = $urandom;
      enq_inst1        = $urandom;
      enq_inst2        = $urandom;
      enq_invalid2     = 1'($urandom);
      enq_predict_cond = 1'($urandom);
      enq_bhr          = GSH_BHR_LEN'($urandom);
   endtask

   // Check outputs against the model, then advance one clock and update the model.
   task automatic step();
      pkt_t h, cur;
      bit   ef, df;
      @(negedge clk);
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("enq_ready", 64'(enq_ready), 64'(exp_q.size() < DEPTH));
      chk("deq_valid", 64'(deq_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         h = exp_q[0];
         chk("deq_pc", 64'(deq_pc), 64'(h.pc));
         chk("deq_npc", 64'(deq_npc), 64'(h.npc));
         chk("deq_inst1", 64'(deq_inst1), 64'(h.i1));
         chk("deq_inst2", 64'(deq_inst2), 64'(h.i2));
         chk("deq_invalid2", 64'(deq_invalid2), 64'(h.inv2));
         chk("deq_predict_cond", 64'(deq_predict_cond), 64'(h.pcnd));
         chk("deq_bhr", 64'(deq_bhr), 64'(h.bhr));
      end
      cur = '{enq_pc, enq_npc, enq_inst1, enq_inst2, enq_invalid2, enq_predict_cond, enq_bhr};
      ef = enq_valid && (exp_q.size() < DEPTH) && !prmiss && !reset;
      df = deq_ready && (exp_q.size() != 0) && !prmiss && !reset;
      @(posedge clk);
      if (reset || prmiss) exp_q.delete();
      else begin
         if (df) void'(exp_q.pop_front());
         if (ef) exp_q.push_back(cur);
      end
      #1;
   endtask

   initial begin
      reset = 1'b1; enq_valid = 1'b0; deq_ready = 1'b0; prmiss = 1'b0;
      set_pkt('0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Idle after reset, then a single packet becomes visible one cycle later.
      step();
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_enq_ready", 64'(enq_ready), 64'd1);
      chk("rst_deq_valid", 64'(deq_valid), 64'd0);
      enq_valid = 1'b1; set_pkt('h100);
      step();
      enq_valid = 1'b0;
      chk("first_deq_valid", 64'(deq_valid), 64'd1);
      chk("first_deq_pc", 64'(deq_pc), 64'h100);
      chk("first_count", 64'(count), 64'd1);
      deq_ready = 1'b1; step(); deq_ready = 1'b0;

      // Fill to full; a held fifth packet waits one cycle even with deq_ready.
      enq_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin set_pkt(ADDR_LEN'(i*8)); step(); end
      chk("full_count", 64'(count), 64'd4);
      chk("full_enq_ready", 64'(enq_ready), 64'd0);
      set_pkt('h20); deq_ready = 1'b1;
      step();
      chk("fifth_held_count", 64'(count), 64'd3);
      step();
      chk("fifth_taken_count", 64'(count), 64'd3);

      // Sustained enqueue+dequeue across pointer wrap; occupancy constant.
      for (int i = 0; i < 10; i++) begin
         set_pkt(ADDR_LEN'('h28 + i*8)); step();
         chk("stream_count", 64'(count), 64'd3);
      end

      // Flush with a concurrent enqueue: everything, including that packet, dropped.
      prmiss = 1'b1; set_pkt('hDEAD0); step(); prmiss = 1'b0;
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_deq_valid", 64'(deq_valid), 64'd0);
      enq_valid = 1'b0; deq_ready = 1'b0;
      step();

      // Bit-exact payload fields.
      enq_valid = 1'b1; set_pkt('h104);
      enq_invalid2 = 1'b1; enq_predict_cond = 1'b1; enq_npc = 'h200; enq_bhr = 'h2A5;
      step(); enq_valid = 1'b0;
      chk("fld_pc", 64'(deq_pc), 64'h104);
      chk("fld_npc", 64'(deq_npc), 64'h200);
      chk("fld_bhr", 64'(deq_bhr), 64'h2A5);
      chk("fld_flags", 64'({deq_invalid2, deq_predict_cond}), 64'b11);
      deq_ready = 1'b1; step(); deq_ready = 1'b0;

      // Mid-operation reset with two entries.
      enq_valid = 1'b1;
      set_pkt('h300); step(); set_pkt('h308); step();
      enq_valid = 1'b0;
      chk("pre_rst_count", 64'(count), 64'd2);
      reset = 1'b1; step(); reset = 1'b0;
      chk("mid_rst_count", 64'(count), 64'd0);
      chk("mid_rst_enq_ready", 64'(enq_ready), 64'd1);
      chk("mid_rst_deq_valid", 64'(deq_valid), 64'd0);

      // Random traffic with occasional flushes.
      for (int i = 0; i < 400; i++) begin
         enq_valid = ($urandom_range(0, 3) != 0);
         deq_ready = ($urandom_range(0, 2) != 0);
         prmiss    = ($urandom_range(0, 29) == 0);
         set_pkt($urandom);
         step();
      end
      enq_valid = 1'b0; prmiss = 1'b0; deq_ready = 1'b1;
      for (int i = 0; i < 6; i++) step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling buffer between the fetch stage and decode. Captures each fetch packet (PC, up to two instructions, second-slot-invalid flag, predicted next PC, prediction bit, global history snapshot) and holds it in a small circular FIFO. Decode drains the FIFO independently of fetch. A branch-mispredict flush (`prmiss`) discards every buffered packet, because all buffered packets are younger than any branch already in execution.

## Interface
Parameters:
- `DEPTH`, 4: number of packet entries; power of two, ≥2.
- `ADDR_LEN`, `ADDR_LEN`: PC width, from constants header.
- `INSN_LEN`, `INSN_LEN`: instruction width.
- `BHR_LEN`, `GSH_BHR_LEN`: gshare history width.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enq_valid`  in  1  fetch presents a packet.
- `enq_ready`  out  1  queue can accept; `= !full`, independent of `deq_ready`.
- `enq_pc`  in  ADDR_LEN  packet PC.
- `enq_npc`  in  ADDR_LEN  predicted next PC.
- `enq_inst1`, `enq_inst2`  in  INSN_LEN  slot 0 and slot 1 instructions.
- `enq_invalid2`  in  1  slot 1 is not a valid instruction.
- `enq_predict_cond`  in  1  predicted-taken bit.
- `enq_bhr`  in  BHR_LEN  history snapshot.
- `deq_valid`  out  1  head entry valid.
- `deq_ready`  in  1  decode accepts the head entry.
- `deq_pc`, `deq_npc`, `deq_inst1`, `deq_inst2`, `deq_invalid2`, `deq_predict_cond`, `deq_bhr`  out  as enq  head entry fields.
- `prmiss`  in  1  flush all entries.
- `count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage: DEPTH entries. Pointers `rdptr` and `wrptr` are $clog2(DEPTH) bits wide and wrap modulo DEPTH. Occupancy is tracked in `count`.
- Enqueue fires when `enq_valid && enq_ready && !prmiss`. The fields are written at `wrptr`, and `wrptr` increments.
- Dequeue fires when `deq_valid && deq_ready && !prmiss`. `rdptr` increments.
- `count` next value = count + enq_fire − deq_fire. Simultaneous enqueue and dequeue leaves `count` unchanged.
- `deq_valid = (count != 0)`. The `deq_*` fields are read combinationally from entry `rdptr`. Their values are don't-care when `deq_valid` is 0.
- `prmiss` has priority over everything. In the next cycle `rdptr = wrptr = 0` and `count = 0`, and any enqueue in the same cycle is dropped.
- Full (`count == DEPTH`): `enq_ready` = 0. No overwrite can occur, even if `deq_ready` = 1 in that cycle. The packet is accepted on the following cycle.
- Empty: `deq_valid` = 0. There is no bypass path, so an enqueued packet is never visible in the cycle it is written.
- `enq_valid` while `enq_ready` = 0 has no effect. Fetch must hold its PC.
- Entry payload is not reset. Only pointers and `count` are reset.

## Timing
- Reset (synchronous): `rdptr = wrptr = 0`, `count = 0`. Outputs after reset: `deq_valid` = 0, `enq_ready` = 1, `count` = 0.
- Reset asserted mid-operation behaves exactly like `prmiss`: all entries discarded on the next edge.
- Latency: a packet enqueued at edge t gives `deq_valid` = 1 after edge t, so it can be dequeued in cycle t+1.
- Throughput: one enqueue and one dequeue per cycle, sustained.
- `enq_ready` depends only on registered `count`. There is no combinational path from `deq_ready` to `enq_ready`, or from `enq_*` to `deq_*`.
- Order is strict FIFO across pointer wrap-around.

## Structure
- `ADDR_LEN`, `INSN_LEN`, `GSH_BHR_LEN` come from the shared constants header. Add `FQ_DEPTH` (4) and `FQ_PKT_LEN` (2·ADDR_LEN + 2·INSN_LEN + 2 + GSH_BHR_LEN) there.
- The packet is stored as one concatenated vector of `FQ_PKT_LEN` bits.
- One sub-module, `fetch_queue_ram`: DEPTH×FQ_PKT_LEN register array with one synchronous write port and one asynchronous read port. Pointer and count control stays in `fetch_queue`.

## Test plan
- Reset, then idle: `deq_valid` = 0, `enq_ready` = 1, `count` = 0. Enqueue pc = 0x100 with `deq_ready` = 0 → next cycle `deq_valid` = 1, `deq_pc` = 0x100, `count` = 1.
- Enqueue 4 packets (pc 0x00, 0x08, 0x10, 0x18), `deq_ready` = 0 → `count` = 4, `enq_ready` = 0. A fifth packet held with `deq_ready` = 1 is not accepted that cycle and is accepted the next cycle.
- Continuous enqueue and dequeue for 10 cycles with pc incremented by 8 each cycle → `deq_pc` sequence is in order across pointer wrap, and `count` stays constant.
- Queue holds 3 packets and `prmiss` = 1 together with `enq_valid` = 1 → next cycle `count` = 0 and `deq_valid` = 0. The dropped packet never appears.
- Enqueue pc = 0x104 with `invalid2` = 1, `predict_cond` = 1, npc = 0x200, bhr = 0x2A5 → dequeued fields match bit-exactly.
- `reset` asserted with the queue at `count` = 2 → next cycle `count` = 0, `enq_ready` = 1, `deq_valid` = 0.
